// File: rtl/muxn_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muxn_scan_pkg
//  Description : Shared definitions for the muxn_scan block: mode encodings
//                and a constant clog2 helper used to size index/counter fields.
//  Revision    : 1.0  initial release
// ============================================================================
package muxn_scan_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muxn_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : muxn_scan_if
//  Description : Bus bundle for muxn_scan.
//                master : drives en, mode, s, din; observes y, ch, y_vld
//                slave  : the mux itself (inverse directions)
//                en     - clock enable, low freezes the block
//                mode   - 0 manual select, 1 auto scan
//                s      - manual channel select (SW bits)
//                din    - packed channel data, channel k at din[k*W +: W]
//                y      - registered selected data
//                ch     - index of channel currently on y
//                y_vld  - y carries data from a legal channel
//  Revision    : 1.0  initial release
// ============================================================================
interface muxn_scan_if
  import muxn_scan_pkg::*;
#(
  parameter int W = 2,
  parameter int N = 4
);
  localparam int SW = (clog2(N) > 1) ? clog2(N) : 1;

  logic          en;
  logic          mode;
  logic [SW-1:0] s;
  logic [N*W-1:0] din;
  logic [W-1:0]  y;
  logic [SW-1:0] ch;
  logic          y_vld;

  modport master (output en, mode, s, din, input y, ch, y_vld);
  modport slave  (input en, mode, s, din, output y, ch, y_vld);

endinterface
`default_nettype wire

// File: rtl/muxn_scan_scan_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : scan_cnt
//  Description : Dwell counter plus channel counter for scan mode. The channel
//                advances after DWELL enabled scan cycles and wraps N-1 -> 0.
//                clk       - system clock, rising edge
//                rst_n     - asynchronous active-low reset
//                en_i      - clock enable, low holds both counters
//                scan_i    - block is in scan mode this cycle
//                load_i    - scan starts this cycle at load_ch_i
//                load_ch_i - start channel (already range-checked)
//                ch_o      - channel to show this cycle (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module scan_cnt
  import muxn_scan_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int DWELL = 8,
  localparam int SW    = (clog2(N) > 1) ? clog2(N) : 1,
  localparam int CW    = clog2(DWELL) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          scan_i,
  input  logic          load_i,
  input  logic [SW-1:0] load_ch_i,
  output logic [SW-1:0] ch_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [SW-1:0] cur_ch;
  logic [CW-1:0] cur_cnt;

  // On a load the start position behaves as if it were already the stored
  // state, so the first scan cycle both shows and counts the start channel.
  always_comb begin
    cur_ch  = load_i ? load_ch_i : ch_q;
    cur_cnt = load_i ? '0 : cnt_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    if (!scan_i) begin
      cnt_d = '0;
    end else if (cur_cnt == CW'(DWELL - 1)) begin
      cnt_d = '0;
      ch_d  = (cur_ch == SW'(N - 1)) ? '0 : cur_ch + SW'(1);
    end else begin
      cnt_d = cur_cnt + CW'(1);
      ch_d  = cur_ch;
    end
  end

  assign ch_o = cur_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ch_q  <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
      ch_q  <= ch_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muxn_scan.sv
`default_nettype none
// ============================================================================
//  Module      : muxn_scan
//  Description : N-input, W-bit multiplexer with registered output and an
//                optional auto-scan mode that dwells DWELL cycles per channel.
//                clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - muxn_scan_if.slave (en, mode, s, din, y, ch, y_vld)
//  Revision    : 1.0  initial release
// ============================================================================
module muxn_scan
  import muxn_scan_pkg::*;
#(
  parameter  int W     = 2,
  parameter  int N     = 4,
  parameter  int DWELL = 8,
  localparam int SW    = (clog2(N) > 1) ? clog2(N) : 1
) (
  input  logic     clk,
  input  logic     rst_n,
  muxn_scan_if.slave bus
);

  mode_e         mode_q;
  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          vld_q, vld_d;

  logic          s_ok;
  logic          load;
  logic          is_scan;
  logic [SW-1:0] start_ch;
  logic [SW-1:0] scan_ch;
  logic [SW-1:0] sel_ch;
  logic [W-1:0]  sel_data;

  // Extra bit keeps the compare correct when N == 2**SW.
  assign s_ok     = ({1'b0, bus.s} < (SW + 1)'(N));
  assign start_ch = s_ok ? bus.s : '0;
  assign is_scan  = (bus.mode == MODE_SCAN);
  assign load     = bus.en && is_scan && (mode_q == MODE_MANUAL);

  scan_cnt #(
    .N     (N),
    .DWELL (DWELL)
  ) u_scan_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (bus.en),
    .scan_i    (is_scan),
    .load_i    (load),
    .load_ch_i (start_ch),
    .ch_o      (scan_ch)
  );

  // Leaving scan mode needs no bookkeeping: selection follows the live mode
  // input, and the scan position is reloaded on the next entry.
  always_comb begin
    sel_ch   = is_scan ? scan_ch : bus.s;
    sel_data = '0;
    // Only legal slices are ever addressed; an out-of-range index yields 0.
    for (int k = 0; k < N; k++) begin
      if (sel_ch == SW'(k)) begin
        sel_data = bus.din[k*W +: W];
      end
    end
    vld_d = is_scan || s_ok;
    y_d   = vld_d ? sel_data : '0;
    ch_d  = sel_ch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
      mode_q <= MODE_MANUAL;
    end else if (bus.en) begin
      y_q    <= y_d;
      ch_q   <= ch_d;
      vld_q  <= vld_d;
      mode_q <= mode_e'(bus.mode);
    end else begin
      vld_q  <= 1'b0;
    end
  end

  assign bus.y     = y_q;
  assign bus.ch    = ch_q;
  assign bus.y_vld = vld_q;

endmodule
`default_nettype wire

// File: tb/tb_muxn_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muxn_scan
//  Description : Directed bench for muxn_scan. dut_a: W=2 N=4 DWELL=3,
//                dut_b: W=2 N=3 DWELL=2. Expected outputs are queued when a
//                step is driven and compared one clock later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muxn_scan;

  typedef struct packed {
    logic [1:0] y;
    logic [1:0] ch;
    logic       vld;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  muxn_scan_if #(.W(2), .N(4)) bus_a ();
  muxn_scan_if #(.W(2), .N(3)) bus_b ();

  muxn_scan #(.W(2), .N(4), .DWELL(3)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  muxn_scan #(.W(2), .N(3), .DWELL(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus into dut_a (use_b=0) or dut_b (use_b=1),
  // queue the expectation, then compare after the next rising edge.
  task automatic step(input bit use_b, input logic en, input logic mode,
                      input logic [1:0] s, input logic [1:0] ey,
                      input logic [1:0] ech, input logic ev);
    exp_t e;
    step_no++;
    if (use_b) begin
      bus_b.en = en; bus_b.mode = mode; bus_b.s = s;
    end else begin
      bus_a.en = en; bus_a.mode = mode; bus_a.s = s;
    end
    e.y = ey; e.ch = ech; e.vld = ev;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (use_b) begin
      check("y_b",   32'(bus_b.y),     32'(e.y));
      check("ch_b",  32'(bus_b.ch),    32'(e.ch));
      check("vld_b", 32'(bus_b.y_vld), 32'(e.vld));
    end else begin
      check("y_a",   32'(bus_a.y),     32'(e.y));
      check("ch_a",  32'(bus_a.ch),    32'(e.ch));
      check("vld_a", 32'(bus_a.y_vld), 32'(e.vld));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int scan_seq [17] = '{0,0,0,1,1,1,2,2,2,3,3,3,0,0,0,1,1};
    int b_seq    [8]  = '{0,0,1,1,2,2,0,0};

    rst_n = 1'b0;
    bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.s = '0; bus_a.din = 8'b11_10_01_00;
    bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.s = '0; bus_b.din = 6'b11_10_01;
    repeat (2) @(posedge clk);
    #1;
    check("rst_y",   32'(bus_a.y),     32'd0);
    check("rst_ch",  32'(bus_a.ch),    32'd0);
    check("rst_vld", 32'(bus_a.y_vld), 32'd0);
    rst_n = 1'b1;

    // Manual select: din[k] = k.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 2'(k), 2'(k), 2'(k), 1'b1);
    end

    // Scan with wrap; din reversed so y = 3 - ch.
    bus_a.din = 8'b00_01_10_11;
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 1'b1, 2'd0, 2'(3 - scan_seq[i]), 2'(scan_seq[i]), 1'b1);
    end

    // Asynchronous reset mid-scan, observed before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_y",   32'(bus_a.y),     32'd0);
    check("arst_ch",  32'(bus_a.ch),    32'd0);
    check("arst_vld", 32'(bus_a.y_vld), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Scan restarts at channel 0.
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'd3, 2'd0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'd3, 2'd0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'd3, 2'd0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 2'd1, 1'b1);

    // Enable low for 5 cycles with dwell counter at 1: hold, y_vld low.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 2'd1, 1'b0);
    end
    // Channel 1 gets exactly DWELL-1 = 2 more cycles.
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 2'd1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 2'd1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 2'd2, 1'b1);

    // Scan -> manual takes effect immediately; manual -> scan starts at s.
    step(1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 2'd1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 2'd2, 2'd1, 2'd2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2'd2, 2'd1, 2'd2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2'd2, 2'd1, 2'd2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2'd2, 2'd1, 2'd2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2'd2, 2'd0, 2'd3, 1'b1);

    // Non-power-of-2 N=3: din_b[k] = k + 1.
    bus_a.en = 1'b0;
    step(1'b1, 1'b1, 1'b0, 2'd3, 2'd0, 2'd3, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd2, 2'd3, 2'd2, 1'b1);
    step(1'b1, 1'b1, 1'b0, 2'd3, 2'd0, 2'd3, 1'b0);
    // Enter scan with s=3: start at channel 0, wrap 2 -> 0.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1, 2'd3, 2'(b_seq[i] + 1), 2'(b_seq[i]), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muxn_scan.md
Name: muxn_scan

Overview:
- Parametrised N-input, W-bit-wide multiplexer with a registered output. Successor to the 2:1 single-bit gate-level mux.
- Two modes:
  - Manual: the `s` input picks the channel.
  - Scan: the block steps through channels 0..N-1 itself, staying on each for DWELL cycles.
- Sits between multi-channel sources (switches/sensors in the lab designs) and a single display or output path. Reports which channel is currently on `y`.

Parameters:
- W, 2, data width per channel (>=1)
- N, 4, number of input channels (2..16; need not be a power of 2)
- DWELL, 8, cycles spent on each channel in scan mode (>=1)
- SW, derived localparam = clog2(N) (min 1), select/channel index width; not overridable

Ports:
- clk, input, 1, system clock, rising edge
- rst_n, input, 1, asynchronous active-low reset
- en, input, 1, clock enable; low freezes all state
- mode, input, 1, 0 = manual select, 1 = auto scan
- s, input, SW, manual channel select
- din, input, N*W, packed inputs; channel k occupies din[k*W +: W]
- y, output, W, registered selected data
- ch, output, SW, index of the channel whose data is on y
- y_vld, output, 1, y holds valid data from a legal channel

Behaviour:
- Reset:
  - Asynchronous on rst_n low: y=0, ch=0, y_vld=0, dwell counter=0, scan channel=0, mode_q=0.
  - Release is synchronous to the next clk edge. Reset mid-scan abandons the scan; after release, scan restarts at channel 0.
- Latency: 1 cycle.
  - y, ch and y_vld at edge t+1 reflect the din, s and mode sampled at edge t.
  - No combinational path from inputs to outputs.
- en=0: y, ch, dwell counter, scan channel and mode_q hold. y_vld is forced to 0 while en is low.
- Manual mode (mode=1'b0), en=1:
  - s < N: y <= din[s], ch <= s, y_vld <= 1.
  - s >= N (only possible when N is not a power of 2): y <= 0, ch <= s, y_vld <= 0.
  - The dwell counter is held at 0.
- Scan mode (mode=1'b1), en=1:
  - y <= din[scan_ch], ch <= scan_ch, y_vld <= 1.
  - Dwell counter increments each cycle.
  - When the counter reaches DWELL-1: it clears to 0 and scan_ch advances by 1.
  - Wrap-around: scan_ch == N-1 advances to 0 (not to 2^SW-1 when N is not a power of 2).
  - DWELL=1: channel advances every enabled cycle.
- Mode transitions (mode_q = registered mode, updated only when en=1):
  - 0 -> 1: scan starts at the current s, or at 0 if s >= N; dwell counter = 0. In that first cycle y shows din[start channel].
  - 1 -> 0: takes effect immediately. The scan position is discarded and manual select applies the same cycle.
- din changes are followed every enabled cycle; there is no capture/hold of data beyond the output register.
- Arithmetic: dwell counter width = clog2(DWELL)+1. All index compares are unsigned. Non-power-of-2 N must never select an undefined slice.

Decomposition:
- Shared package/header mux_pkg:
  - clog2 constant function
  - mode encodings MODE_MANUAL=1'b0, MODE_SCAN=1'b1
- Sub-module scan_cnt:
  - Parameters N, DWELL.
  - Ports clk, rst_n, en, load, load_ch, ch_o.
  - Contains the dwell counter and the channel counter with wrap.
- Top-level holds the select mux, range check and output register.

Test Plan:
- Reset: assert rst_n=0 mid-scan with en=1, mode=1 -> y=0, ch=0, y_vld=0 immediately, without waiting for a clk edge. After release, scan restarts at ch=0.
- Manual select, W=2, N=4, din={2'b11,2'b10,2'b01,2'b00}, s stepped 0..3 -> one cycle later y = 00, 01, 10, 11 and ch = 0, 1, 2, 3, with y_vld=1 throughout.
- Scan with wrap, N=4, DWELL=3 -> ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. y tracks din of each channel. Channel changes exactly every 3 cycles.
- Non-power-of-2, N=3:
  - Manual s=3 -> y=0, y_vld=0.
  - Scan -> ch sequence ...,2,0; never 3.
  - Switch 0 -> 1 with s=3 -> scan starts at ch=0.
- Enable gating: drop en for 5 cycles mid-dwell (counter=1) -> y and ch hold, y_vld=0. When en returns, the current channel gets exactly DWELL-1 further cycles before advancing.
- Mode switch:
  - Manual s=2 then mode 0 -> 1 -> first scan output ch=2, stays for DWELL cycles, then ch=3.
  - mode 1 -> 0 with s=1 -> next cycle ch=1.
